// File: rtl/taylor_pkg.sv
// Shared types and constants for the Taylor-series engine.
// Holds the coefficient-generation helper used to build the ROM contents at elaboration time.
package taylor_pkg;

    typedef enum logic [1:0] {
        MODE_EXP = 2'd0,
        MODE_COS = 2'd1,
        MODE_SIN = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MULA,
        S_MULB,
        S_MULC,
        S_ACC,
        S_DONE
    } state_e;

    function automatic int one_q(input int frac);
        return 1 << frac;
    endfunction

    function automatic int coef_w(input int frac);
        return frac + 1;
    endfunction

    // Round-to-nearest of 1/d in 1.FRAC, where d is the per-term divisor of each series.
    function automatic int coef_val(input int mode, input int k, input int frac);
        int d;
        case (mode)
            1:       d = (2 * k - 1) * (2 * k);
            2:       d = (2 * k) * (2 * k + 1);
            default: d = k;
        endcase
        return ((2 * one_q(frac)) + d) / (2 * d);
    endfunction

endpackage

// File: rtl/taylor_coef_rom.sv
// Coefficient ROM indexed by (mode, k), one-cycle registered read.
// Contents are generated by a constant function from FRAC and NTERMS.
module taylor_coef_rom
    import taylor_pkg::*;
#(
    parameter int FRAC   = 8,
    parameter int NTERMS = 15,
    localparam int KW    = $clog2(NTERMS + 1),
    localparam int CW    = coef_w(FRAC)
) (
    input  logic          clk,
    input  logic [1:0]    mode_i,
    input  logic [KW-1:0] k_i,
    output logic [CW-1:0] coef_o
);

    localparam int NENT = 3 * (NTERMS + 1);

    function automatic logic [NENT*CW-1:0] build_rom();
        logic [NENT*CW-1:0] r;
        r = '0;
        for (int m = 0; m < 3; m++) begin
            for (int k = 1; k <= NTERMS; k++) begin
                r = r | ((NENT*CW)'(coef_val(m, k, FRAC)) << (CW * (m * (NTERMS + 1) + k)));
            end
        end
        return r;
    endfunction

    localparam logic [NENT*CW-1:0] ROM = build_rom();

    int idx;

    always_comb begin
        idx = 0;
        if (mode_i == 2'd1 || mode_i == 2'd2) begin
            idx = int'(mode_i) * (NTERMS + 1);
        end
        idx = idx + int'(k_i);
    end

    always_ff @(posedge clk) begin
        coef_o <= CW'(ROM >> (CW * idx));
    end

endmodule

// File: rtl/taylor_series_engine.sv
// Iterative fixed-point exp/cos/sin evaluator with start/done handshake.
// Build option: define TAYLOR_SAT_EN for saturating accumulate and term clipping.
module taylor_series_engine
    import taylor_pkg::*;
#(
    parameter int W      = 10,
    parameter int FRAC   = 8,
    parameter int NTERMS = 15,
    localparam int KW    = $clog2(NTERMS + 1),
    localparam int CW    = coef_w(FRAC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [W-1:0]    x,
    input  logic [FRAC-1:0] tol,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    result,
    output logic [KW-1:0]   terms_used,
    output logic            sat
);

    localparam int MB = (W > CW) ? W : CW;
    localparam logic [W-1:0] ONE = W'(one_q(FRAC));

    state_e          state_q;
    mode_e           mode_q;
    logic [W-1:0]    x_q, t_q, p_q, acc_q, result_q;
    logic [FRAC-1:0] tol_q;
    logic [KW-1:0]   k_q, terms_q;
    logic            busy_q, done_q;

    logic [CW-1:0]   coef;
    logic [W-1:0]    mul_a;
    logic [MB-1:0]   mul_b;
    logic [W+MB-1:0] prod;
    logic [W-1:0]    prod_mid, term_d, acc_d;
    logic            sub, stop_tol, unused_prod;

    taylor_coef_rom #(.FRAC(FRAC), .NTERMS(NTERMS)) u_rom (
        .clk    (clk),
        .mode_i (mode_q),
        .k_i    (k_q),
        .coef_o (coef)
    );

`ifdef TAYLOR_SAT_EN
    logic [W:0] acc_ext;
    logic       acc_clip;
    logic       sat_q;
`endif

    // Single shared multiplier: t*x in MULA, p*x in MULB, p*coef in MULC.
    always_comb begin
        mul_a    = (state_q == S_MULA) ? t_q : p_q;
        mul_b    = (state_q == S_MULC) ? MB'(coef) : MB'(x_q);
        prod     = {{MB{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        prod_mid = prod[FRAC+W-1:FRAC];
        sub      = (mode_q != MODE_EXP) && k_q[0];
        stop_tol = t_q < W'(tol_q);
`ifdef TAYLOR_SAT_EN
        term_d      = (|prod[W+MB-1:FRAC+W]) ? '1 : prod_mid;
        acc_ext     = sub ? ({1'b0, acc_q} - {1'b0, t_q}) : ({1'b0, acc_q} + {1'b0, t_q});
        acc_clip    = acc_ext[W];
        acc_d       = acc_clip ? (sub ? '0 : '1) : acc_ext[W-1:0];
        unused_prod = ^prod[FRAC-1:0];
`else
        term_d      = prod_mid;
        acc_d       = sub ? (acc_q - t_q) : (acc_q + t_q);
        unused_prod = ^{prod[W+MB-1:FRAC+W], prod[FRAC-1:0]};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_EXP;
            x_q      <= '0;
            tol_q    <= '0;
            t_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            terms_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TAYLOR_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q     <= x;
                        tol_q   <= tol;
                        mode_q  <= (mode == 2'd1) ? MODE_COS : ((mode == 2'd2) ? MODE_SIN : MODE_EXP);
                        busy_q  <= 1'b1;
                        state_q <= S_INIT;
                    end
                end
                S_INIT: begin
                    acc_q   <= (mode_q == MODE_SIN) ? x_q : ONE;
                    t_q     <= (mode_q == MODE_SIN) ? x_q : ONE;
                    k_q     <= KW'(1);
                    terms_q <= '0;
`ifdef TAYLOR_SAT_EN
                    sat_q   <= 1'b0;
`endif
                    state_q <= S_MULA;
                end
                S_MULA: begin
                    p_q     <= prod_mid;
                    state_q <= (mode_q == MODE_EXP) ? S_MULC : S_MULB;
                end
                S_MULB: begin
                    p_q     <= prod_mid;
                    state_q <= S_MULC;
                end
                S_MULC: begin
                    t_q     <= term_d;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    if (stop_tol) begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        acc_q   <= acc_d;
                        terms_q <= k_q;
`ifdef TAYLOR_SAT_EN
                        if (acc_clip) sat_q <= 1'b1;
`endif
                        if (k_q == KW'(NTERMS)) begin
                            result_q <= acc_d;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            k_q     <= k_q + KW'(1);
                            state_q <= S_MULA;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign terms_used = terms_q;
`ifdef TAYLOR_SAT_EN
    assign sat        = sat_q;
`else
    assign sat        = 1'b0;
`endif

endmodule

// File: tb/tb_taylor_series_engine.sv
// Self-checking bench for taylor_series_engine (W=10, FRAC=8, NTERMS=15).
// Honours TAYLOR_SAT_EN in its reference model.
module tb_taylor_series_engine;

    localparam int W      = 10;
    localparam int FRAC   = 8;
    localparam int NTERMS = 15;
    localparam int KW     = 4;

    logic            clk = 1'b0;
    logic            rst, start;
    logic [1:0]      mode;
    logic [W-1:0]    x;
    logic [FRAC-1:0] tol;
    logic            busy, done, sat;
    logic [W-1:0]    result;
    logic [KW-1:0]   terms_used;

    taylor_series_engine #(.W(W), .FRAC(FRAC), .NTERMS(NTERMS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .x          (x),
        .tol        (tol),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .terms_used (terms_used),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: series coefficient 1/d rounded to nearest in 1.FRAC.
    function automatic int coef_of(input int m, input int k);
        real d;
        if (m == 1)      d = real'((2 * k - 1) * (2 * k));
        else if (m == 2) d = real'((2 * k) * (2 * k + 1));
        else             d = real'(k);
        return $rtoi(real'(1 << FRAC) / d + 0.5);
    endfunction

    function automatic void model(input int md, input int xv, input int tv,
                                  output int res, output int terms, output int sv, output int iters);
        int m, acc, t, p, prod, mask;
        bit trig;
        m     = (md == 1 || md == 2) ? md : 0;
        trig  = (m != 0);
        mask  = (1 << W) - 1;
        acc   = (m == 2) ? xv : (1 << FRAC);
        t     = acc;
        terms = 0;
        sv    = 0;
        iters = NTERMS;
        for (int k = 1; k <= NTERMS; k++) begin
            p = ((t * xv) >> FRAC) & mask;
            if (trig) p = ((p * xv) >> FRAC) & mask;
            prod = p * coef_of(m, k);
            t = (prod >> FRAC) & mask;
`ifdef TAYLOR_SAT_EN
            if ((prod >> (FRAC + W)) != 0) t = mask;
`endif
            if (t < tv) begin
                iters = k;
                break;
            end
            if (trig && (k % 2 == 1)) acc = acc - t;
            else                      acc = acc + t;
`ifdef TAYLOR_SAT_EN
            if (acc > mask) begin
                acc = mask;
                sv  = 1;
            end else if (acc < 0) begin
                acc = 0;
                sv  = 1;
            end
`else
            acc = acc & mask;
`endif
            terms = k;
        end
        res = acc;
    endfunction

    // Scoreboard: predicts accept, busy window and the done cycle from the model.
    int cyc = 0, ready_c = 0, d_c = 0;
    bit run = 0, valid = 0, exp_done = 0;
    int pend_res, pend_terms, pend_sat, pend_iters;
    int exp_res = 0, exp_terms = 0, exp_sat = 0;

    always @(posedge clk) begin
        cyc++;
        exp_done = 0;
        if (rst) begin
            run       = 0;
            exp_res   = 0;
            exp_terms = 0;
            exp_sat   = 0;
            ready_c   = cyc + 1;
            valid     = 1;
        end else if (!run && start && cyc >= ready_c) begin
            model(int'(mode), int'(x), int'(tol), pend_res, pend_terms, pend_sat, pend_iters);
            d_c = cyc + 1 + pend_iters * ((mode == 2'd1 || mode == 2'd2) ? 4 : 3);
            run = 1;
        end else if (run && cyc == d_c) begin
            exp_res   = pend_res;
            exp_terms = pend_terms;
            exp_sat   = pend_sat;
            exp_done  = 1;
            run       = 0;
            ready_c   = cyc + 2;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("busy", int'(busy), int'(run));
            check("done", int'(done), int'(exp_done));
            check("result", int'(result), exp_res);
            if (!run) begin
                check("terms_used", int'(terms_used), exp_terms);
                check("sat", int'(sat), exp_sat);
            end
        end
    end

    task automatic do_run(input int md, input int xv, input int tv,
                          output int r, output int tu, output int sv, output int edges);
        bit got;
        @(negedge clk);
        mode  = 2'(md);
        x     = W'(xv);
        tol   = FRAC'(tv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        got   = 0;
        while (edges < 300 && !got) begin
            if (done) got = 1;
            else begin
                @(negedge clk);
                edges++;
            end
        end
        check("done_seen", int'(got), 1);
        r  = int'(result);
        tu = int'(terms_used);
        sv = int'(sat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, tu, sv, ed, mr, mt, ms, mi, ndone;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        x     = '0;
        tol   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_terms", int'(terms_used), 0);
        rst = 1'b0;

        // Pin the model against hand-computed values.
        model(0, 256, 1, mr, mt, ms, mi);
        check("model_exp1_res", mr, 693);
        check("model_exp1_terms", mt, 5);
        model(1, 256, 0, mr, mt, ms, mi);
        check("model_cos1_res", mr, 138);
        model(2, 128, 1, mr, mt, ms, mi);
        check("model_sin05_res", mr, 123);

        do_run(0, 256, 1, r, tu, sv, ed);
        check_range("exp1_result", r, 693, 697);
        check("exp1_busy_at_done", int'(busy), 0);

        do_run(0, 0, 1, r, tu, sv, ed);
        check("exp0_result", r, 256);
        check("exp0_terms", tu, 0);
        check("exp0_latency", ed, 5);

        do_run(2, 128, 1, r, tu, sv, ed);
        check_range("sin05_result", r, 121, 123);

        do_run(1, 0, 1, r, tu, sv, ed);
        check("cos0_result", r, 256);
        check("cos0_terms", tu, 0);

        do_run(1, 256, 0, r, tu, sv, ed);
        check("cos1_terms", tu, 15);
        check_range("cos1_result", r, 136, 140);

        do_run(3, 256, 1, r, tu, sv, ed);
        check("reserved_mode_result", r, 693);

        // Start pulses during busy and in the DONE cycle must be ignored.
        @(negedge clk);
        mode  = 2'd0;
        x     = W'(256);
        tol   = FRAC'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        x     = W'(512);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_done_count", ndone, 1);
        check("ignore_result", int'(result), 693);
        check("ignore_idle", int'(busy), 0);

        // Reset while a COS run sits in MULB.
        @(negedge clk);
        mode  = 2'd1;
        x     = W'(256);
        tol   = FRAC'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        do_run(1, 256, 1, r, tu, sv, ed);
        check("after_abort_result", r, 138);
        check("after_abort_terms", tu, 2);

        do_run(0, 1023, 0, r, tu, sv, ed);
`ifdef TAYLOR_SAT_EN
        check("ovf_result", r, 1023);
        check("ovf_sat", sv, 1);
`else
        check("ovf_result", r, 288);
        check("ovf_sat", sv, 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
